ps2_scancode_receiver: RTL and testbench
========================================

Name: ps2_scancode_receiver

Overview:
PS/2 device-to-host receiver that sits directly upstream of the keyboard command controller. It synchronises and filters the raw ps2_clock/ps2_data pins and deframes 11-bit PS/2 frames with start, parity and stop checks. It decodes the E0 (extended) and F0 (break) prefixes and emits exactly one single-cycle valid pulse per key press (make code). Break sequences and device housekeeping bytes never reach the controller, so a key press never triggers it twice.

Parameters:
FILTER_LEN, 8, consecutive identical synchronised samples required before the filtered ps2_clock changes level
TIMEOUT_CYCLES, 20000, clk_in cycles without a filtered falling edge mid-frame before the frame is aborted (200 us at 100 MHz)

Ports:
clk_in  input  1  system clock, 100 MHz
reset  input  1  synchronous, active-high reset
ps2_clock  input  1  raw PS/2 clock pin, asynchronous
ps2_data  input  1  raw PS/2 data pin, asynchronous
scancode  output  8  last accepted make code; held until the next accept
valid  output  1  one-cycle pulse: scancode/extended are new this cycle
extended  output  1  accepted code was preceded by E0
frame_error  output  1  one-cycle pulse on parity/stop/timeout failure

Behaviour:
- One clock (clk_in); reset is synchronous and active-high. Every register updates only on the rising edge of clk_in.
- Reset values: scancode=0, valid=0, extended=0, frame_error=0. The filtered clock resets to 1, the bit counter to 0, and both prefix flags to 0. Reset asserted mid-frame discards the partial frame with no error pulse.
- Input stage:
  - Both pins pass through a 2-flop synchroniser.
  - The filtered clock takes a new level only after FILTER_LEN consecutive equal synchronised samples; shorter glitches are ignored.
  - A falling edge is a filtered 1->0 transition, detected as a one-cycle strobe. Synchronised data is sampled on that strobe.
- Deframer (bit counter 0..10, LSB first):
  - Idle: on an edge, if the sampled bit = 0 (start), advance to bit 1. If the sampled bit = 1, stay idle with no error.
  - Bits 1-8: shift into the data byte.
  - Bit 9: parity. Odd parity is required: XOR of the 8 data bits and the parity bit = 1.
  - Bit 10: stop, must be 1. Then return to idle.
  - Parity or stop failure: frame_error pulses for one cycle after the stop edge, the byte is dropped, and both prefix flags clear.
  - Timeout: while the counter is non-zero, a watchdog counts clk_in cycles since the last edge. On reaching TIMEOUT_CYCLES, the frame aborts, frame_error pulses for one cycle, the counter returns to 0 and the prefix flags clear. The watchdog reloads to 0 on every edge.
- Byte decoder (acts on each good byte, in the cycle after the stop edge):
  - E0: set ext flag, no output.
  - F0: set brk flag, no output.
  - AA, FA, FE, EE, 00, FF, E1: discarded, flags unchanged, no output.
  - Any other byte, brk=1: discarded; clear both flags.
  - Any other byte, brk=0: scancode<=byte, extended<=ext, valid=1 for exactly one cycle; clear both flags.
- Latency: valid rises on the second clk_in rising edge after the cycle in which the stop-bit falling-edge strobe is high (one cycle to accept the frame, one to register the outputs). It is fixed and identical for every byte.
- valid and frame_error are never high in the same cycle.

Test Plan:
1. Frame 0x5A (parity bit 1, stop 1), PS/2 clock 12.5 kHz -> valid high exactly 1 cycle, scancode=0x5A, extended=0; no frame_error.
2. Frames F0, 5A -> no valid pulse; scancode stays 0x5A from step 1; a following 0x5A frame -> valid again.
3. Frames E0, 75 -> valid once, scancode=0x75, extended=1. Then E0, F0, 75 -> no valid. Then 0x6B -> valid, extended=0.
4. Frame 0x16 with parity bit 0 (wrong) -> frame_error pulse, no valid. Good 0x16 -> valid, scancode=0x16. Frame with stop=0 -> frame_error.
5. Start bit plus 4 data bits, then ps2_clock held high for TIMEOUT_CYCLES+10 -> a single frame_error pulse; next full frame 0x45 -> valid, scancode=0x45. ps2_clock low glitch of 3 cycles mid-idle -> no effect.
6. reset for 1 cycle after 5 bits of a frame -> outputs 0, no frame_error; next frame 0x4D -> valid, scancode=0x4D. Frame 0xAA -> no valid.

Source files
------------

// File: rtl/ps2_scancode_receiver.sv
// ps2_scancode_receiver
//   PS/2 device-to-host receiver for the keyboard command controller.
//   It synchronises and glitch-filters the raw PS/2 pins and deframes
//   11-bit frames (start, 8 data bits LSB first, odd parity, stop).
//   It also decodes the E0 (extended) and F0 (break) prefixes, so each
//   key press produces exactly one valid pulse carrying its make code.
//
// Parameters
//   FILTER_LEN      consecutive equal synchronised samples before the
//                   filtered PS/2 clock changes level
//   TIMEOUT_CYCLES  clk_in cycles without a falling edge mid-frame before
//                   the frame is aborted
//
// Ports
//   clk_in       in   system clock
//   reset        in   synchronous, active-high reset
//   ps2_clock    in   raw PS/2 clock pin (asynchronous)
//   ps2_data     in   raw PS/2 data pin (asynchronous)
//   scancode     out  [7:0] last accepted make code, held until next accept
//   valid        out  one-cycle pulse: scancode/extended are new
//   extended     out  accepted code was preceded by E0
//   frame_error  out  one-cycle pulse on parity, stop or timeout failure
module ps2_scancode_receiver #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic       ps2_clock,
  input  logic       ps2_data,
  output logic [7:0] scancode,
  output logic       valid,
  output logic       extended,
  output logic       frame_error
);

  localparam int FCNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int WD_W   = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // Odd parity: data bits plus parity bit must XOR to 1.
  function automatic logic odd_parity_ok(input logic [7:0] d, input logic p);
    return ^{d, p};
  endfunction

  // Device housekeeping bytes that are swallowed without touching prefixes.
  function automatic logic is_housekeeping(input logic [7:0] b);
    case (b)
      8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF, 8'hE1: return 1'b1;
      default:                                         return 1'b0;
    endcase
  endfunction

  // ---- Stage p0: two-flop synchronisers -----------------------------------
  logic clk_sync_p0, clk_sync_p1;
  logic dat_sync_p0, dat_sync_p1;

  // The clock chain resets high so that leaving reset can never look like
  // a falling edge.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      clk_sync_p0 <= 1'b1;
      clk_sync_p1 <= 1'b1;
    end else begin
      clk_sync_p0 <= ps2_clock;
      clk_sync_p1 <= clk_sync_p0;
    end
  end

  always_ff @(posedge clk_in) begin
    dat_sync_p0 <= ps2_data;
    dat_sync_p1 <= dat_sync_p0;
  end

  // ---- Glitch filter and falling-edge strobe ------------------------------
  logic              filt_clk;
  logic [FCNT_W-1:0] filt_cnt;
  logic              fall_stb;

  // filt_cnt counts consecutive samples that disagree with filt_clk; the
  // FILTER_LEN-th disagreeing sample flips the level.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      filt_clk <= 1'b1;
      filt_cnt <= '0;
      fall_stb <= 1'b0;
    end else begin
      fall_stb <= 1'b0;
      if (clk_sync_p1 == filt_clk) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FCNT_W'(FILTER_LEN - 1)) begin
        filt_clk <= clk_sync_p1;
        filt_cnt <= '0;
        fall_stb <= filt_clk;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  // ---- Deframer -----------------------------------------------------------
  state_t            state, state_nxt;
  logic [2:0]        bit_idx, bit_idx_nxt;
  logic [7:0]        shreg, shreg_nxt;
  logic              par_ok, par_ok_nxt;
  logic [WD_W-1:0]   wd_cnt, wd_cnt_nxt;
  logic              vld_nxt, err_nxt;

  always_comb begin
    state_nxt   = state;
    bit_idx_nxt = bit_idx;
    shreg_nxt   = shreg;
    par_ok_nxt  = par_ok;
    wd_cnt_nxt  = '0;
    vld_nxt     = 1'b0;
    err_nxt     = 1'b0;

    // Watchdog runs only mid-frame; an edge always wins over a timeout.
    if (state != S_IDLE && !fall_stb) begin
      if (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1)) begin
        state_nxt = S_IDLE;
        err_nxt   = 1'b1;
      end else begin
        wd_cnt_nxt = wd_cnt + 1'b1;
      end
    end

    if (fall_stb) begin
      case (state)
        S_IDLE: begin
          if (!dat_sync_p1) begin
            state_nxt   = S_DATA;
            bit_idx_nxt = 3'd0;
          end
        end
        S_DATA: begin
          shreg_nxt   = {dat_sync_p1, shreg[7:1]};
          bit_idx_nxt = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_nxt = S_PARITY;
        end
        S_PARITY: begin
          par_ok_nxt = odd_parity_ok(shreg, dat_sync_p1);
          state_nxt  = S_STOP;
        end
        S_STOP: begin
          state_nxt = S_IDLE;
          if (par_ok && dat_sync_p1) vld_nxt = 1'b1;
          else                       err_nxt = 1'b1;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // ---- Stage p1: accepted byte / frame error ------------------------------
  logic       vld_p1, err_p1;
  logic [7:0] byte_p1;

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state  <= S_IDLE;
      wd_cnt <= '0;
      vld_p1 <= 1'b0;
      err_p1 <= 1'b0;
    end else begin
      state  <= state_nxt;
      wd_cnt <= wd_cnt_nxt;
      vld_p1 <= vld_nxt;
      err_p1 <= err_nxt;
    end
  end

  always_ff @(posedge clk_in) begin
    bit_idx <= bit_idx_nxt;
    shreg   <= shreg_nxt;
    par_ok  <= par_ok_nxt;
    byte_p1 <= shreg;
  end

  // ---- Stage p2: prefix decode and registered outputs ---------------------
  logic ext_flag, brk_flag;

  always_ff @(posedge clk_in) begin
    if (reset) begin
      ext_flag    <= 1'b0;
      brk_flag    <= 1'b0;
      scancode    <= 8'h00;
      extended    <= 1'b0;
      valid       <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      valid       <= 1'b0;
      frame_error <= err_p1;
      if (err_p1) begin
        ext_flag <= 1'b0;
        brk_flag <= 1'b0;
      end else if (vld_p1) begin
        if (byte_p1 == 8'hE0) begin
          ext_flag <= 1'b1;
        end else if (byte_p1 == 8'hF0) begin
          brk_flag <= 1'b1;
        end else if (!is_housekeeping(byte_p1)) begin
          // A byte after F0 is the break code of a released key: drop it.
          if (!brk_flag) begin
            scancode <= byte_p1;
            extended <= ext_flag;
            valid    <= 1'b1;
          end
          ext_flag <= 1'b0;
          brk_flag <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_scancode_receiver.sv
// tb_ps2_scancode_receiver
//   Self-checking bench for ps2_scancode_receiver. A driver serialises PS/2
//   frames onto the pins; each frame that should produce output pushes its
//   expected result onto a scoreboard queue, and a monitor pops and compares
//   whenever the receiver pulses valid or frame_error. The PS/2 bit period
//   and timeout are shortened so the whole run stays small.
module tb_ps2_scancode_receiver;

  localparam int FILTER_LEN = 8;
  localparam int TIMEOUT    = 500;
  localparam int HALF       = 20;   // clk_in cycles per PS/2 clock half-period

  logic       clk_in = 1'b0;
  logic       reset;
  logic       ps2_clock;
  logic       ps2_data;
  logic [7:0] scancode;
  logic       valid;
  logic       extended;
  logic       frame_error;

  ps2_scancode_receiver #(
    .FILTER_LEN    (FILTER_LEN),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk_in     (clk_in),
    .reset      (reset),
    .ps2_clock  (ps2_clock),
    .ps2_data   (ps2_data),
    .scancode   (scancode),
    .valid      (valid),
    .extended   (extended),
    .frame_error(frame_error)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    bit         err;
    logic [7:0] code;
    bit         ext;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   stop_cyc = 0;
  int   first_lat = -1;

  always @(posedge clk_in) cyc++;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic push_code(input logic [7:0] code, input bit ext);
    exp_t e;
    e.err = 1'b0; e.code = code; e.ext = ext;
    sb.push_back(e);
  endtask

  task automatic push_err();
    exp_t e;
    e.err = 1'b1; e.code = 8'h00; e.ext = 1'b0;
    sb.push_back(e);
  endtask

  // One PS/2 bit: data settles while the clock is high, then the clock falls.
  task automatic ps2_bit(input logic d, input bit is_stop);
    ps2_data = d;
    repeat (HALF) @(posedge clk_in);
    #1;
    ps2_clock = 1'b0;
    if (is_stop) stop_cyc = cyc;
    repeat (HALF) @(posedge clk_in);
    #1;
    ps2_clock = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input logic stop);
    ps2_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i], 1'b0);
    ps2_bit((~^b) ^ bad_par, 1'b0);
    ps2_bit(stop, 1'b1);
    ps2_data = 1'b1;
  endtask

  task automatic send_partial(input logic [7:0] b, input int nbits);
    ps2_bit(1'b0, 1'b0);
    for (int i = 0; i < nbits; i++) ps2_bit(b[i], 1'b0);
    ps2_data = 1'b1;
    repeat (HALF) @(posedge clk_in);
    #1;
  endtask

  // Every expected output must have appeared within the settle window.
  task automatic drain(input string tag);
    repeat (40) @(posedge clk_in);
    #1;
    check_eq(tag, sb.size(), 0);
    sb.delete();
  endtask

  task automatic good(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b1);
  endtask

  // Monitor
  always @(negedge clk_in) begin
    if (valid && frame_error) check_eq("valid_and_error", 1, 0);
    if (valid || frame_error) begin
      if (sb.size() == 0) begin
        check_eq("unexpected_output", {valid, frame_error}, 2'b00);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_eq("error_pulse", frame_error, e.err);
        if (!e.err) begin
          int lat;
          check_eq("scancode", scancode, e.code);
          check_eq("extended", extended, e.ext);
          lat = cyc - stop_cyc;
          check_eq("latency_range", (lat >= FILTER_LEN + 2 && lat <= FILTER_LEN + 8), 1);
          if (first_lat < 0) first_lat = lat;
          else check_eq("latency_const", lat, first_lat);
        end
      end
    end
  end

  initial begin
    reset     = 1'b1;
    ps2_clock = 1'b1;
    ps2_data  = 1'b1;
    repeat (5) @(posedge clk_in);
    #1;
    reset = 1'b0;
    @(negedge clk_in);
    check_eq("rst_scancode", scancode, 8'h00);
    check_eq("rst_valid", valid, 1'b0);
    check_eq("rst_extended", extended, 1'b0);
    check_eq("rst_frame_error", frame_error, 1'b0);
    repeat (5) @(posedge clk_in);
    #1;

    // 1: plain make code
    push_code(8'h5A, 1'b0); good(8'h5A); drain("t1_5a");

    // 2: break sequence is swallowed, scancode held; next press reported
    good(8'hF0); good(8'h5A); drain("t2_break");
    check_eq("t2_hold", scancode, 8'h5A);
    push_code(8'h5A, 1'b0); good(8'h5A); drain("t2_again");

    // 3: extended press, extended release, then a normal key
    push_code(8'h75, 1'b1); good(8'hE0); good(8'h75); drain("t3_ext");
    good(8'hE0); good(8'hF0); good(8'h75); drain("t3_ext_break");
    push_code(8'h6B, 1'b0); good(8'h6B); drain("t3_6b");

    // 4: parity error, good frame, stop error
    push_err(); send_frame(8'h16, 1'b1, 1'b1); drain("t4_parity");
    push_code(8'h16, 1'b0); good(8'h16); drain("t4_16");
    push_err(); send_frame(8'h16, 1'b0, 1'b0); ps2_data = 1'b1; drain("t4_stop");

    // 5: stalled frame times out once; recovery; idle glitch ignored
    send_partial(8'h45, 4);
    push_err();
    repeat (TIMEOUT + 10) @(posedge clk_in);
    #1;
    check_eq("t5_timeout", sb.size(), 0);
    sb.delete();
    push_code(8'h45, 1'b0); good(8'h45); drain("t5_45");
    ps2_clock = 1'b0;
    repeat (3) @(posedge clk_in);
    #1;
    ps2_clock = 1'b1;
    drain("t5_glitch");
    push_code(8'h1C, 1'b0); good(8'h1C); drain("t5_after_glitch");

    // 6: reset mid-frame, then normal operation; housekeeping byte dropped
    send_partial(8'h4D, 4);
    @(posedge clk_in); #1;
    reset = 1'b1;
    @(posedge clk_in); #1;
    reset = 1'b0;
    @(negedge clk_in);
    check_eq("t6_scancode", scancode, 8'h00);
    check_eq("t6_extended", extended, 1'b0);
    check_eq("t6_valid", valid, 1'b0);
    check_eq("t6_frame_error", frame_error, 1'b0);
    repeat (TIMEOUT + 10) @(posedge clk_in);
    #1;
    push_code(8'h4D, 1'b0); good(8'h4D); drain("t6_4d");
    good(8'hAA); drain("t6_aa");
    check_eq("t6_hold", scancode, 8'h4D);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    repeat (90000) @(posedge clk_in);
    n_checks++;
    n_errors++;
    $display("FAIL global_timeout: run did not complete");
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
